// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared state, key index and BCD constants for the stopwatch controller
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int KEY_STARTSTOP = 0;
  localparam int KEY_CLEAR     = 1;
  localparam int KEY_LAP       = 2;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// rtl/stopwatch_ctrl_key_debounce.sv - synchronizer, stability debouncer and press pulse for one active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], key_n};
    cnt_d   = '0;
    level_d = level_q;
    // The level only moves once the synchronized key has disagreed with it for DEBOUNCE_CYC cycles in a row.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - start/pause/clear FSM, gated tick prescaler, BCD counter and lap freeze
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 5000000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int NDIGITS      = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic [2:0]             KEY_N,
  output logic [4*NDIGITS-1:0]   BCD,
  output logic                   RUNNING,
  output logic                   LAP_HOLD,
  output logic [1:0]             STATE,
  output logic                   TICK,
  output logic                   WRAP
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int W  = 4 * NDIGITS;

  logic [2:0]    key_press;
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  latch_q, latch_d;
  logic [W-1:0]  bcd_q, bcd_d;
  logic          lap_q, lap_d;
  logic [W-1:0]  cnt_inc;
  logic          all_nines;
  logic          inc_carry;
  logic          tick;
  logic          start_ev, clear_ev, lap_ev;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .key_n (KEY_N[k]),
      .press (key_press[k])
    );
  end

  assign start_ev = key_press[KEY_STARTSTOP];
  assign clear_ev = key_press[KEY_CLEAR];
  assign lap_ev   = key_press[KEY_LAP];
  assign tick     = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    cnt_inc   = cnt_q;
    all_nines = 1'b1;
    inc_carry = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (cnt_q[4*i +: 4] != BCD_MAX) all_nines = 1'b0;
      if (inc_carry) begin
        if (cnt_q[4*i +: 4] == BCD_MAX) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    latch_d = latch_q;

    // Counting is driven by the current state, so a tick on the same edge as a pause still lands.
    if (state_q == ST_RUN) begin
      if (tick) begin
        presc_d = '0;
        cnt_d   = cnt_inc;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!clear_ev && start_ev) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_ev) begin
          state_d = ST_PAUSE;
        end else if (lap_ev) begin
          lap_d = ~lap_q;
          if (!lap_q) latch_d = cnt_q;
        end
      end
      ST_PAUSE: begin
        if (clear_ev)      state_d = ST_IDLE;
        else if (start_ev) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      presc_d = '0;
      cnt_d   = '0;
      lap_d   = 1'b0;
      latch_d = '0;
    end

    bcd_d = lap_d ? latch_d : cnt_d;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      latch_q <= '0;
      lap_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      lap_q   <= lap_d;
      bcd_q   <= bcd_d;
    end
  end

  assign BCD      = bcd_q;
  assign RUNNING  = (state_q == ST_RUN);
  assign LAP_HOLD = lap_q;
  assign STATE    = state_q;
  assign TICK     = tick;
  assign WRAP     = tick & all_nines;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl against an elapsed-time reference model
module tb_stopwatch_ctrl;

  localparam int TD   = 4;
  localparam int DC   = 3;
  localparam int ND   = 2;
  localparam int MODC = 100;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N  = 1'b0;
  logic [2:0]    KEY_N    = 3'b111;
  logic [4*ND-1:0] BCD;
  logic          RUNNING, LAP_HOLD, TICK, WRAP;
  logic [1:0]    STATE;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYC(DC), .NDIGITS(ND)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .KEY_N    (KEY_N),
    .BCD      (BCD),
    .RUNNING  (RUNNING),
    .LAP_HOLD (LAP_HOLD),
    .STATE    (STATE),
    .TICK     (TICK),
    .WRAP     (WRAP)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct { int edge_no; int bcd; int wrap; } tick_t;
  typedef struct { int edge_no; int st; } st_t;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int wraps_seen = 0;
  logic [2:0] ev_at [int];
  tick_t tick_q[$];
  st_t   st_q[$];

  // Model: elapsed RUN cycles determine prescaler and count by plain arithmetic.
  int m_state = 0, m_run = 0, m_lap = 0, m_latch = 0, m_disp = 0;

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  initial forever begin
    @(posedge CLOCK_50 or negedge RESET_N);
    if (!RESET_N) begin
      m_state = 0; m_run = 0; m_lap = 0; m_latch = 0; m_disp = 0;
      tick_q.delete(); st_q.delete(); ev_at.delete();
    end else begin
      int e, pre, tk, nst;
      edge_n++;
      e = 0;
      if (ev_at.exists(edge_n)) begin
        e = int'(ev_at[edge_n]);
        ev_at.delete(edge_n);
      end
      pre = (m_run / TD) % MODC;
      tk  = (m_state == 1 && (m_run % TD) == TD - 1) ? 1 : 0;
      if (m_state == 1) m_run++;
      nst = m_state;
      if (e[1] && m_state != 1) begin
        if (m_state == 2) begin
          nst = 0; m_run = 0; m_lap = 0; m_latch = 0;
        end
      end else if (e[0]) begin
        nst = (m_state == 1) ? 2 : 1;
      end else if (e[2] && m_state == 1) begin
        if (m_lap == 0) m_latch = pre;
        m_lap = 1 - m_lap;
      end
      if (nst != m_state) st_q.push_back('{edge_n, nst});
      m_state = nst;
      m_disp = (m_lap != 0) ? m_latch : (m_run / TD) % MODC;
      if (tk != 0) tick_q.push_back('{edge_n, to_bcd(m_disp), (pre == MODC - 1) ? 1 : 0});
    end
  end

  initial begin : monitor
    int pend, pend_wrap, prev_st;
    tick_t t;
    st_t s;
    pend = 0; pend_wrap = 0; prev_st = 0;
    forever begin
      @(negedge CLOCK_50);
      if (!RESET_N) begin
        pend = 0; prev_st = 0;
      end else begin
        if (pend != 0) begin
          if (tick_q.size() == 0) begin
            chk("tick_unexpected", 1, 0);
          end else begin
            t = tick_q.pop_front();
            chk("tick_edge", edge_n, t.edge_no);
            chk("tick_bcd", int'(BCD), t.bcd);
            chk("tick_wrap", pend_wrap, t.wrap);
          end
        end
        while (tick_q.size() > 0 && tick_q[0].edge_no < edge_n) begin
          t = tick_q.pop_front();
          chk("tick_missing", 0, 1);
        end
        pend = int'(TICK);
        pend_wrap = int'(WRAP);
        if (TICK && WRAP) wraps_seen++;
        if (int'(STATE) != prev_st) begin
          if (st_q.size() == 0) begin
            chk("state_unexpected", int'(STATE), prev_st);
          end else begin
            s = st_q.pop_front();
            chk("state_val", int'(STATE), s.st);
            chk("state_edge", edge_n, s.edge_no);
          end
          prev_st = int'(STATE);
        end
        while (st_q.size() > 0 && st_q[0].edge_no < edge_n) begin
          s = st_q.pop_front();
          chk("state_missing", int'(STATE), s.st);
        end
        chk("bcd_live", int'(BCD), to_bcd(m_disp));
        chk("lap_hold", int'(LAP_HOLD), m_lap);
        chk("running", int'(RUNNING), (m_state == 1) ? 1 : 0);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
  endtask

  task automatic press(input logic [2:0] mask, input int hold, input int gap);
    int k;
    @(posedge CLOCK_50);
    #1;
    k = edge_n + DC + 3;
    if (ev_at.exists(k)) ev_at[k] = ev_at[k] | mask;
    else ev_at[k] = mask;
    KEY_N = KEY_N & ~mask;
    repeat (hold) @(posedge CLOCK_50);
    #1;
    KEY_N = KEY_N | mask;
    repeat (gap) @(posedge CLOCK_50);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, int'(STATE), 0);
    chk({tag, "_bcd"}, int'(BCD), 0);
    chk({tag, "_running"}, int'(RUNNING), 0);
    chk({tag, "_lap"}, int'(LAP_HOLD), 0);
    chk({tag, "_tick"}, int'(TICK), 0);
    chk({tag, "_wrap"}, int'(WRAP), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    wait_cyc(4);
    @(negedge CLOCK_50);
    chk_all_zero("reset");
    @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    wait_cyc(3);

    for (int i = 0; i < 10; i++) begin
      @(posedge CLOCK_50);
      #1;
      KEY_N[0] = ~KEY_N[0];
      wait_cyc(1);
    end
    wait_cyc(12);
    chk("bounce_idle", int'(STATE), 0);

    press(3'b001, 10, 1);
    for (int i = 0; i < 20; i++) begin
      if (STATE == 2'd1) break;
      @(negedge CLOCK_50);
    end
    chk("start_run", int'(STATE), 1);

    wait_cyc(420);
    chk("wrap_seen", (wraps_seen > 0) ? 1 : 0, 1);

    press(3'b001, 5, 50);
    press(3'b001, 5, 30);

    press(3'b100, 5, 20);
    press(3'b100, 5, 10);
    press(3'b010, 5, 10);
    chk("clear_in_run", int'(STATE), 1);

    press(3'b001, 5, 10);
    press(3'b010, 5, 10);
    chk("clear_state", int'(STATE), 0);
    chk("clear_bcd", int'(BCD), 0);
    chk("clear_lap", int'(LAP_HOLD), 0);

    press(3'b001, 5, 30);
    press(3'b001, 5, 10);
    chk("pause_state", int'(STATE), 2);
    press(3'b011, 6, 10);
    chk("simul_clear_wins", int'(STATE), 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] m;
      m = 3'b001 << $urandom_range(0, 2);
      press(m, $urandom_range(4, 10), $urandom_range(5, 40));
    end
    wait_cyc(15);
    chk("tick_q_empty", tick_q.size(), 0);
    chk("state_q_empty", st_q.size(), 0);

    for (int t = 0; t < 3 && m_state != 1; t++) press(3'b001, 5, 10);
    wait_cyc(7);
    chk("pre_reset_run", int'(STATE), 1);
    @(posedge CLOCK_50);
    #3;
    RESET_N = 1'b0;
    #1;
    chk_all_zero("async_reset");
    wait_cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Key-driven controller that sequences the board's seconds/tenths counter datapath: debounces pushbuttons, runs a start/pause/clear state machine, gates a tick prescaler and drives a BCD counter with lap-freeze.
- Sits between raw KEY inputs and the per-digit SEG7 decoders. The top level feeds one BCD nibble per HEX display.

Parameters:
- TICK_DIV, 5000000, CLOCK_50 cycles per count tick (0.1 s at 50 MHz); must be >= 2.
- DEBOUNCE_CYC, 1000000, cycles a synchronized key level must stay stable before it is accepted (20 ms); must be >= 1.
- NDIGITS, 4, number of BCD digits; must be 1..8.

Ports:
- CLOCK_50, in, 1, system clock.
- RESET_N, in, 1, asynchronous active-low reset.
- KEY_N, in, 3, raw active-low buttons: [0] start/stop, [1] clear, [2] lap.
- BCD, out, 4*NDIGITS, displayed count; nibble 0 is the least significant digit.
- RUNNING, out, 1, high in the RUN state.
- LAP_HOLD, out, 1, high while the display is frozen.
- STATE, out, 2, encoded state: 0 IDLE, 1 RUN, 2 PAUSE.
- TICK, out, 1, one-cycle pulse on each count increment.
- WRAP, out, 1, one-cycle pulse when the count rolls from all-9s to all-0s.

Behaviour:
- Reset:
  - All outputs are 0, STATE is IDLE, and the prescaler, counter and lap latch are 0.
  - Debounced key levels reset to released (1).
  - Reset asserted mid-count clears everything immediately.
- Key path, per key:
  - 2-flop synchronizer, then the debouncer. The debounced level changes only after the synchronized input has held a new value for DEBOUNCE_CYC consecutive cycles.
  - A press event is a one-cycle pulse on the debounced 1->0 edge. Release produces no event.
  - Latency from a stable raw press to the event is DEBOUNCE_CYC+3 cycles.
- FSM:
  - IDLE --start--> RUN.
  - RUN --start--> PAUSE.
  - PAUSE --start--> RUN.
  - PAUSE --clear--> IDLE.
  - IDLE --clear--> IDLE (no change).
  - Clear in RUN is ignored.
  - Entering IDLE zeroes the counter, prescaler and lap latch.
- Prescaler:
  - Increments only in RUN and holds its value in PAUSE, so resume keeps the partial tick.
  - When it equals TICK_DIV-1, it returns to 0 and TICK is asserted that cycle.
- Counter:
  - On TICK it increments in BCD. A digit at 9 goes to 0 and carries; a digit at 0-8 increments and stops the carry.
  - All digits 9 goes to all 0, and WRAP is asserted in the same cycle as TICK.
  - Counter digits never hold A-F.
- Lap:
  - A lap event in RUN toggles LAP_HOLD. On 0->1, the current counter value is latched into the display register.
  - While LAP_HOLD=1, BCD shows the latched value and the counter keeps running. On 1->0, BCD returns to live.
  - Lap events in IDLE or PAUSE are ignored.
  - Start/stop does not change LAP_HOLD.
- BCD output:
  - Registered; it reflects a counter increment one cycle after TICK.
- Simultaneous events in one cycle:
  - Priority is clear > start/stop > lap. Lower-priority events in that cycle are dropped.
  - Tick coincident with start/stop in RUN: the increment is applied, then the state goes to PAUSE, and the prescaler holds at 0.
  - Tick coincident with lap 0->1: the latch captures the pre-increment value.
- STATE encoding 3 is unreachable; if decoded, the FSM goes to IDLE.

Decomposition:
- Shared package:
  - State encoding constants (ST_IDLE=0, ST_RUN=1, ST_PAUSE=2).
  - Key index constants (KEY_STARTSTOP=0, KEY_CLEAR=1, KEY_LAP=2).
  - BCD digit max constant (9).
- One sub-module: key_debounce.
  - Contents: synchronizer, stability counter, debounced level and press pulse.
  - Parameter: DEBOUNCE_CYC.
  - Instantiated three times.
- FSM, prescaler, BCD counter and lap latch stay in stopwatch_ctrl.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, DEBOUNCE_CYC=3, NDIGITS=2.
- Reset and start: release RESET_N, hold KEY_N[0]=0 for 10 cycles.
  - STATE goes 0->1 exactly 6 cycles after KEY_N[0] falls.
  - TICK fires every 4 cycles; BCD reads 0x01, 0x02, ... after each TICK.
- Bounce rejection: toggle KEY_N[0] every 2 cycles for 20 cycles, then release.
  - No press event; STATE stays IDLE.
- BCD carry and wrap:
  - Run until BCD=0x09; the next TICK gives BCD=0x10, WRAP=0.
  - Continue to 0x99; the next TICK gives BCD=0x00, and WRAP and TICK are high in the same cycle.
- Pause/resume keeps partial tick:
  - Pause when the prescaler is at 2, wait 50 cycles: BCD is unchanged and no TICK.
  - Resume: first TICK arrives 2 cycles after the state returns to RUN.
- Clear and lap:
  - Lap in RUN at BCD=0x05: BCD holds 0x05 and LAP_HOLD=1 while TICKs continue. Lap again: BCD shows the live value, e.g. 0x08.
  - Clear while RUN: ignored.
  - Pause, then clear: STATE=0, BCD=0x00, LAP_HOLD=0.
- Simultaneous and reset: press start/stop and clear together (raw edges aligned) in PAUSE.
  - Clear wins: STATE=IDLE.
  - Assert RESET_N low mid-RUN: all outputs are 0 in the same cycle, without waiting for a clock edge.
